// File: rtl/spmv_pkg.sv
// Shared state encoding and AXI constants for the SpMV vector HBM writer.
package spmv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_AW    = 3'd2,
      ST_WDATA = 3'd3,
      ST_WRESP = 3'd4
   } spmv_state_e;

   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
   localparam int unsigned PAGE_BYTES     = 4096;
   localparam int unsigned PAGE_OFS_W     = 12;

   // AXI size code for a beat of the given byte width.
   function automatic logic [2:0] axi_size(input int unsigned bytes_per_beat);
      return 3'($clog2(bytes_per_beat));
   endfunction

endpackage

// File: rtl/spmv_beat_fifo.sv
// First-word-fall-through beat buffer holding at most one AXI burst of stream data.
module spmv_beat_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 256
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [2**PTR_W];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // The head word is visible without a read request so WDATA can present it at once.
   assign rd_data_o = mem[rd_ptr_q];

endmodule

// File: rtl/spmv_vector_hbm_writer.sv
// Collects vector beats from an AXI stream and writes them to HBM as 4 KB-safe AXI4 INCR bursts.
module spmv_vector_hbm_writer
   import spmv_pkg::*;
#(
   parameter int DATA_W    = 256,
   parameter int ADDR_W    = 64,
   parameter int BURST_LEN = 16
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                cfg_enable,
   input  logic                cfg_addr_load,
   input  logic [ADDR_W-1:0]   cfg_now_addr,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic [DATA_W-1:0]   s_axis_tdata,
   input  logic                s_axis_tlast,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic [7:0]          m_axi_awlen,
   output logic [2:0]          m_axi_awsize,
   output logic [1:0]          m_axi_awburst,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wlast,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   input  logic [1:0]          m_axi_bresp,
   output logic                addr_step_valid,
   output logic [31:0]         addr_step_bytes,
   output logic                busy,
   output logic                err_bresp
);

   localparam int BYTES      = DATA_W / 8;
   localparam int BYTE_SHIFT = $clog2(BYTES);
   localparam int CNT_W      = $clog2(BURST_LEN + 1);
   localparam int PG_W       = PAGE_OFS_W + 1;

   spmv_state_e       state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic              pend_q, pend_d;
   logic              err_q, err_d;
   logic              step_q, step_d;
   logic [31:0]       step_bytes_q, step_bytes_d;

   logic [PG_W-1:0]   page_left;
   logic [PG_W-1:0]   page_beats;
   logic [CNT_W-1:0]  limit;
   logic [CNT_W-1:0]  count_inc;
   logic [31:0]       burst_bytes;
   logic              s_hs, w_hs, b_hs;
   logic              load_now;

   // Beats that still fit before the next 4 KB page boundary.
   assign page_left  = PG_W'(PAGE_BYTES) - {1'b0, cur_addr_q[PAGE_OFS_W-1:0]};
   assign page_beats = page_left >> BYTE_SHIFT;
   assign limit      = (page_beats < PG_W'(BURST_LEN)) ? page_beats[CNT_W-1:0] : CNT_W'(BURST_LEN);

   assign s_axis_tready   = (state_q == ST_FILL) && (count_q < limit);
   assign m_axi_awvalid   = (state_q == ST_AW);
   assign m_axi_awaddr    = cur_addr_q;
   assign m_axi_awlen     = 8'(count_q - CNT_W'(1));
   assign m_axi_awsize    = axi_size(BYTES);
   assign m_axi_awburst   = AXI_BURST_INCR;
   assign m_axi_wvalid    = (state_q == ST_WDATA);
   assign m_axi_wstrb     = '1;
   assign m_axi_wlast     = m_axi_wvalid && (beat_q == count_q - CNT_W'(1));
   assign m_axi_bready    = (state_q == ST_WRESP);
   assign addr_step_valid = step_q;
   assign addr_step_bytes = step_bytes_q;
   assign busy            = (state_q != ST_IDLE);
   assign err_bresp       = err_q;

   assign s_hs        = s_axis_tvalid && s_axis_tready;
   assign w_hs        = m_axi_wvalid && m_axi_wready;
   assign b_hs        = m_axi_bready && m_axi_bvalid;
   assign count_inc   = count_q + CNT_W'(s_hs);
   assign burst_bytes = 32'(count_q) << BYTE_SHIFT;

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      beat_d       = beat_q;
      cur_addr_d   = cur_addr_q;
      pend_d       = pend_q;
      pend_addr_d  = pend_addr_q;
      err_d        = err_q;
      step_d       = 1'b0;
      step_bytes_d = step_bytes_q;
      load_now     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_enable && s_axis_tvalid) state_d = ST_FILL;
         end
         ST_FILL: begin
            count_d = count_inc;
            if (s_hs && (s_axis_tlast || (count_inc == limit))) begin
               state_d = ST_AW;
            end else if (!cfg_enable) begin
               state_d = (count_inc != '0) ? ST_AW : ST_IDLE;
            end
         end
         ST_AW: begin
            if (m_axi_awready) begin
               state_d = ST_WDATA;
               beat_d  = '0;
            end
         end
         ST_WDATA: begin
            if (m_axi_wready) begin
               beat_d = beat_q + CNT_W'(1);
               if (m_axi_wlast) state_d = ST_WRESP;
            end
         end
         ST_WRESP: begin
            if (m_axi_bvalid) begin
               step_d       = 1'b1;
               step_bytes_d = burst_bytes;
               cur_addr_d   = cur_addr_q + ADDR_W'(burst_bytes);
               if (m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
               count_d      = '0;
               state_d      = cfg_enable ? ST_FILL : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Address loads are only applied between bursts; otherwise they wait for the current one to finish.
      load_now = (state_q == ST_IDLE) || (state_d == ST_IDLE) || b_hs;
      if (pend_q && load_now) begin
         cur_addr_d = pend_addr_q;
         pend_d     = 1'b0;
      end
      if (cfg_addr_load) begin
         if (load_now) begin
            cur_addr_d = cfg_now_addr;
            pend_d     = 1'b0;
         end else begin
            pend_d      = 1'b1;
            pend_addr_d = cfg_now_addr;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         beat_q       <= '0;
         cur_addr_q   <= '0;
         pend_addr_q  <= '0;
         pend_q       <= 1'b0;
         err_q        <= 1'b0;
         step_q       <= 1'b0;
         step_bytes_q <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         beat_q       <= beat_d;
         cur_addr_q   <= cur_addr_d;
         pend_addr_q  <= pend_addr_d;
         pend_q       <= pend_d;
         err_q        <= err_d;
         step_q       <= step_d;
         step_bytes_q <= step_bytes_d;
      end
   end

   spmv_beat_fifo #(
      .DEPTH (BURST_LEN),
      .WIDTH (DATA_W)
   ) u_beat_fifo (
      .clk_i     (aclk),
      .rst_i     (areset),
      .wr_en_i   (s_hs),
      .wr_data_i (s_axis_tdata),
      .rd_en_i   (w_hs),
      .rd_data_o (m_axi_wdata)
   );

endmodule

// File: tb/tb_spmv_vector_hbm_writer.sv
// Directed and randomized bench for spmv_vector_hbm_writer against a burst-splitting reference model.
module tb_spmv_vector_hbm_writer;

   localparam int DATA_W    = 256;
   localparam int ADDR_W    = 64;
   localparam int BURST_LEN = 16;
   localparam int BYTES     = DATA_W / 8;

   logic              aclk = 1'b0;
   logic              areset;
   logic              cfg_enable, cfg_addr_load;
   logic [ADDR_W-1:0] cfg_now_addr;
   logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              m_axi_awvalid, m_axi_awready;
   logic [ADDR_W-1:0] m_axi_awaddr;
   logic [7:0]        m_axi_awlen;
   logic [2:0]        m_axi_awsize;
   logic [1:0]        m_axi_awburst;
   logic              m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic [DATA_W-1:0] m_axi_wdata;
   logic [BYTES-1:0]  m_axi_wstrb;
   logic              m_axi_bvalid, m_axi_bready;
   logic [1:0]        m_axi_bresp;
   logic              addr_step_valid, busy, err_bresp;
   logic [31:0]       addr_step_bytes;

   always #5 aclk = ~aclk;

   spmv_vector_hbm_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
      .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable), .cfg_addr_load(cfg_addr_load),
      .cfg_now_addr(cfg_now_addr), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wlast(m_axi_wlast), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_bresp(m_axi_bresp), .addr_step_valid(addr_step_valid), .addr_step_bytes(addr_step_bytes),
      .busy(busy), .err_bresp(err_bresp)
   );

   int checks = 0;
   int failures = 0;

   logic [63:0]  got_aw_addr[$], exp_aw_addr[$];
   logic [7:0]   got_aw_len[$],  exp_aw_len[$];
   logic [255:0] got_w_data[$],  exp_w_data[$];
   bit           got_w_last[$],  exp_w_last[$];
   logic [31:0]  got_step[$],    exp_step[$];

   logic [255:0] beat_data[64];
   bit           beat_last[64];
   bit           hold_wready = 1'b0;
   logic [1:0]   bresp_val = 2'b00;
   int           b_owed = 0;
   logic [63:0]  next_addr = 64'd0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_data(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // AXI slave: samples handshakes at negedge, drives ready/valid just after posedge.
   initial begin : axi_slave
      bit aw_f, w_f, b_f;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      forever begin
         @(negedge aclk);
         aw_f = m_axi_awvalid && m_axi_awready;
         w_f  = m_axi_wvalid && m_axi_wready;
         b_f  = m_axi_bvalid && m_axi_bready;
         if (areset) begin
            b_owed = 0;
            b_f    = 1'b0;
         end else begin
            if (aw_f) begin
               got_aw_addr.push_back(m_axi_awaddr);
               got_aw_len.push_back(m_axi_awlen);
            end
            if (w_f) begin
               got_w_data.push_back(m_axi_wdata);
               got_w_last.push_back(m_axi_wlast);
               if (m_axi_wlast) b_owed++;
            end
            if (b_f) b_owed--;
            if (addr_step_valid) got_step.push_back(addr_step_bytes);
         end
         @(posedge aclk);
         #1;
         m_axi_awready = !areset && ($urandom_range(0, 3) != 0);
         m_axi_wready  = !areset && !hold_wready && ($urandom_range(0, 3) != 0);
         if (areset) m_axi_bvalid = 1'b0;
         else if (!m_axi_bvalid || b_f) m_axi_bvalid = (b_owed > 0) && ($urandom_range(0, 1) == 1);
         m_axi_bresp = bresp_val;
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic prep(input int n);
      for (int i = 0; i < n; i++) begin
         beat_data[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         beat_last[i] = 1'b0;
      end
   endtask

   task automatic send_beat(input int i);
      int cyc;
      bit fire;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_data[i];
      s_axis_tlast  = beat_last[i];
      fire = 1'b0;
      cyc  = 0;
      while (!fire && cyc < 2000) begin
         @(negedge aclk);
         fire = s_axis_tready;
         tick();
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (!fire) check("tready_timeout", 64'(fire), 64'd1);
   endtask

   task automatic go_idle();
      int cyc;
      cfg_enable = 1'b0;
      cyc = 0;
      while (busy && cyc < 1000) begin
         tick();
         cyc++;
      end
      check("go_idle_busy", 64'(busy), 64'd0);
   endtask

   // Reference: split the beat list into bursts limited by BURST_LEN, the 4 KB page and tlast.
   task automatic model(input logic [63:0] base, input int n);
      logic [63:0] a;
      int i, room, lim, k;
      bit stop;
      exp_aw_addr.delete(); exp_aw_len.delete(); exp_w_data.delete();
      exp_w_last.delete();  exp_step.delete();
      a = base;
      i = 0;
      while (i < n) begin
         room = (4096 - int'(a % 64'd4096)) / BYTES;
         lim  = (room < BURST_LEN) ? room : BURST_LEN;
         k    = 0;
         stop = 1'b0;
         while (!stop && k < lim && i < n) begin
            exp_w_data.push_back(beat_data[i]);
            exp_w_last.push_back(1'b0);
            stop = beat_last[i];
            k++;
            i++;
         end
         exp_w_last[exp_w_last.size() - 1] = 1'b1;
         exp_aw_addr.push_back(a);
         exp_aw_len.push_back(8'(k - 1));
         exp_step.push_back(32'(k * BYTES));
         a = a + 64'(k * BYTES);
      end
      next_addr = a;
   endtask

   task automatic compare();
      int nb, nw;
      check("aw_count", 64'(got_aw_addr.size()), 64'(exp_aw_addr.size()));
      check("step_count", 64'(got_step.size()), 64'(exp_step.size()));
      check("w_count", 64'(got_w_data.size()), 64'(exp_w_data.size()));
      nb = (got_aw_addr.size() < exp_aw_addr.size()) ? got_aw_addr.size() : exp_aw_addr.size();
      if (got_step.size() < nb) nb = got_step.size();
      for (int b = 0; b < nb; b++) begin
         $display("burst addr=0x%0h len=%0d step=%0d", got_aw_addr[b], got_aw_len[b], got_step[b]);
         check("awaddr", got_aw_addr[b], exp_aw_addr[b]);
         check("awlen", 64'(got_aw_len[b]), 64'(exp_aw_len[b]));
         check("step_bytes", 64'(got_step[b]), 64'(exp_step[b]));
      end
      nw = (got_w_data.size() < exp_w_data.size()) ? got_w_data.size() : exp_w_data.size();
      for (int w = 0; w < nw; w++) begin
         check_data("wdata", got_w_data[w], exp_w_data[w]);
         check("wlast", 64'(got_w_last[w]), 64'(exp_w_last[w]));
      end
   endtask

   task automatic run_case(input logic [63:0] start, input int n, input bit do_load);
      logic [63:0] base;
      int cyc;
      go_idle();
      got_aw_addr.delete(); got_aw_len.delete(); got_w_data.delete();
      got_w_last.delete();  got_step.delete();
      base = do_load ? start : next_addr;
      if (do_load) begin
         cfg_now_addr  = start;
         cfg_addr_load = 1'b1;
         tick();
         cfg_addr_load = 1'b0;
      end
      cfg_enable = 1'b1;
      for (int i = 0; i < n; i++) send_beat(i);
      cfg_enable = 1'b0;
      model(base, n);
      cyc = 0;
      while (got_step.size() < exp_step.size() && cyc < 3000) begin
         tick();
         cyc++;
      end
      repeat (10) tick();
      compare();
   endtask

   initial begin : main
      int cyc;
      areset = 1'b1; cfg_enable = 1'b0; cfg_addr_load = 1'b0; cfg_now_addr = '0;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
      check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
      check("rst_bready", 64'(m_axi_bready), 64'd0);
      check("rst_step", 64'(addr_step_valid), 64'd0);
      check("rst_err", 64'(err_bresp), 64'd0);
      check("awsize", 64'(m_axi_awsize), 64'd5);
      check("awburst", 64'(m_axi_awburst), 64'd1);
      check("wstrb_ones", 64'(&m_axi_wstrb), 64'd1);
      areset = 1'b0;
      tick();

      // Stream data present but writer disabled: nothing may happen.
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {8{$urandom}};
      repeat (8) tick();
      check("disabled_tready", 64'(s_axis_tready), 64'd0);
      check("disabled_busy", 64'(busy), 64'd0);
      check("disabled_aw", 64'(got_aw_addr.size()), 64'd0);
      s_axis_tvalid = 1'b0;

      prep(16);
      run_case(64'h1000, 16, 1'b1);

      prep(16); beat_last[15] = 1'b1;
      run_case(64'h1F00, 16, 1'b1);

      prep(8); beat_last[2] = 1'b1; beat_last[7] = 1'b1;
      run_case(64'h3000, 8, 1'b1);

      bresp_val = 2'b10;
      prep(4); beat_last[3] = 1'b1;
      run_case(64'h4000, 4, 1'b1);
      check("err_after_slverr", 64'(err_bresp), 64'd1);
      bresp_val = 2'b00;
      prep(4); beat_last[3] = 1'b1;
      run_case(64'h0, 4, 1'b0);
      check("err_sticky", 64'(err_bresp), 64'd1);

      prep(5);
      run_case(64'h5000, 5, 1'b1);
      check("flush_idle_busy", 64'(busy), 64'd0);

      prep(12);
      run_case(64'hFFFF_FFFF_FFFF_FF00, 12, 1'b1);

      for (int r = 0; r < 6; r++) begin
         logic [63:0] st;
         int n;
         st = {$urandom, $urandom} & ~64'h1F;
         if (r % 2 == 0) st[11:0] = 12'(32 * $urandom_range(100, 127));
         n = $urandom_range(1, 40);
         prep(n);
         for (int i = 0; i < n; i++) beat_last[i] = ($urandom_range(0, 4) == 0);
         run_case(st, n, 1'b1);
      end

      // Reset in the middle of a stalled data phase.
      hold_wready = 1'b1;
      prep(4); beat_last[3] = 1'b1;
      go_idle();
      cfg_now_addr = 64'h6000; cfg_addr_load = 1'b1;
      tick();
      cfg_addr_load = 1'b0;
      cfg_enable = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(i);
      cyc = 0;
      while (!m_axi_wvalid && cyc < 500) begin
         tick();
         cyc++;
      end
      check("reached_wdata", 64'(m_axi_wvalid), 64'd1);
      #2 areset = 1'b1;
      #1;
      check("midrst_wvalid", 64'(m_axi_wvalid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_awvalid", 64'(m_axi_awvalid), 64'd0);
      check("midrst_tready", 64'(s_axis_tready), 64'd0);
      check("midrst_err", 64'(err_bresp), 64'd0);
      cfg_enable  = 1'b0;
      hold_wready = 1'b0;
      tick();
      areset = 1'b0;
      next_addr = 64'd0;
      prep(1); beat_last[0] = 1'b1;
      run_case(64'h0, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spmv_vector_hbm_writer.md
SPMV_VECTOR_HBM_WRITER -- requirements
Module: spmv_vector_hbm_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 256, meaning AXI-stream and AXI4 data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 64, meaning HBM byte-address width.
REQ-003 SHALL have parameter BURST_LEN, default 16, meaning maximum beats per AXI4 write burst (power of 2, at most 256).
REQ-004 Ports, clock and reset first; single clock domain:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- cfg_enable  in  1  loader write-mode enable, from config block mode bit 0
- cfg_addr_load  in  1  one-cycle pulse; load cfg_now_addr
- cfg_now_addr  in  ADDR_W  start address, aligned to DATA_W/8
- s_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_W/1  vector data stream
- m_axi_awvalid/awready  out/in  1/1  write address handshake
- m_axi_awaddr  out  ADDR_W  burst address
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  constant log2(DATA_W/8)
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_wvalid/wready  out/in  1/1  write data handshake
- m_axi_wdata  out  DATA_W  write data
- m_axi_wstrb  out  DATA_W/8  all ones
- m_axi_wlast  out  1  last beat of burst
- m_axi_bvalid/bready  in/out  1/1  write response handshake
- m_axi_bresp  in  2  response code
- addr_step_valid  out  1  one-cycle pulse; config block advances its now-address
- addr_step_bytes  out  32  bytes completed by this burst
- busy  out  1  high whenever state is not IDLE
- err_bresp  out  1  sticky; set on any non-OKAY bresp

Function
REQ-005 SHALL implement FSM states IDLE, FILL, AW, WDATA, WRESP.
REQ-006 SHALL keep an internal cur_addr and load it from cfg_now_addr on cfg_addr_load in any state; a load outside IDLE takes effect for the next burst only.
REQ-007 IDLE->FILL SHALL occur when cfg_enable=1 and s_axis_tvalid=1.
REQ-008 limit SHALL equal min(BURST_LEN, (4096 - cur_addr[11:0]) / (DATA_W/8)), so no burst crosses a 4 KB boundary.
REQ-009 In FILL, s_axis_tready SHALL be 1 iff count<limit; each accepted beat SHALL be written into a beat buffer and SHALL increment count.
REQ-010 FILL->AW SHALL occur in the cycle after count reaches limit, or after a beat with tlast=1 is accepted.
REQ-011 If cfg_enable falls during FILL, FILL SHALL go to AW when count>0 (flush) and to IDLE when count=0.
REQ-012 In AW, awvalid SHALL be 1 with awaddr=cur_addr and awlen=count-1, held stable until awready; AW->WDATA SHALL occur on the handshake.
REQ-013 In WDATA, beats SHALL drain from the buffer in order; wlast SHALL be 1 on beat count-1 only; WDATA->WRESP SHALL occur on the wlast handshake.
REQ-014 In WRESP, bready SHALL be 1; on the bvalid handshake the block SHALL pulse addr_step_valid for 1 cycle with addr_step_bytes=count*(DATA_W/8), SHALL add that value to cur_addr, SHALL clear count, and SHALL go to FILL if cfg_enable=1, else IDLE.
REQ-015 A non-OKAY bresp SHALL set err_bresp and SHALL still step the address.
REQ-016 s_axis_tready SHALL be 0 in all states except FILL.
REQ-017 awvalid, wvalid and bready SHALL be 0 outside AW, WDATA and WRESP respectively.
REQ-018 cur_addr arithmetic SHALL be ADDR_W wide and SHALL wrap modulo 2^ADDR_W.

Reset
REQ-019 areset SHALL asynchronously force state=IDLE, count=0, cur_addr=0, err_bresp=0 and all valid, ready, last, step and busy outputs to 0, including when asserted mid-burst.
REQ-020 After reset, the block SHALL not emit any AXI transaction until an accepted stream beat arrives with cfg_enable=1.

Structure
REQ-021 Package spmv_pkg SHALL hold the FSM state enum, the AXI burst/size constants and the 4 KB constant.
REQ-022 The beat buffer SHALL be sub-module spmv_beat_fifo (depth BURST_LEN, width DATA_W, synchronous FWFT).

Verification
REQ-023 Load 0x1000, enable, stream 16 beats -> one burst: awaddr=0x1000, awlen=15, wlast on beat 16, step=512.
REQ-024 Load 0x1F00, stream 16 beats -> bursts of awlen=7 at 0x1F00 and awlen=7 at 0x2000; steps 256 then 256.
REQ-025 tlast on beat 3 -> awlen=2, step=96; next beats form a new burst at base+96.
REQ-026 bresp=SLVERR -> err_bresp=1 and stays 1; step still pulses; next burst proceeds.
REQ-027 Disable after 5 beats in FILL -> awlen=4 flush, then IDLE with busy=0.
REQ-028 areset asserted during WDATA, wready held low -> wvalid=0 immediately, state IDLE, cur_addr=0.
